// File: rtl/nios_cpu_mul_seq.sv
// rtl/nios_cpu_mul_seq.sv - multiply sequencer around a registered 32x32 low-word multiplier cell
module nios_cpu_mul_seq #(
  parameter int MUL_CELL_LATENCY = 1,
  parameter int DATA_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic [DATA_W-1:0] M_mul_src1,
  output logic [DATA_W-1:0] M_mul_src2,
  input  logic [DATA_W-1:0] M_mul_cell_result,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready
);

  localparam int L = MUL_CELL_LATENCY;
  localparam logic [1:0] OP_MUL = 2'b00;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] acc_q;
  logic [1:0]  issue_cnt_q;
  logic [L:0]  tag_vld_q;
  logic [1:0]  tag_idx_q [0:L];

  logic [1:0]  last_idx;
  logic [31:0] pair_a_d, pair_b_d;
  logic        cap_vld, cap_last;
  logic [1:0]  cap_idx;
  logic [63:0] term, acc_d;
  logic [31:0] final_d;

  assign req_ready = (state_q == IDLE) && !reset;
  assign last_idx  = (op_q == OP_MUL) ? 2'd0 : 2'd3;

  // Partial-product operand selection: zero-extended 16-bit halves for high-word ops
  always_comb begin
    pair_a_d = a_q;
    pair_b_d = b_q;
    if (op_q != OP_MUL) begin
      pair_a_d = {16'h0, issue_cnt_q[1] ? a_q[31:16] : a_q[15:0]};
      pair_b_d = {16'h0, issue_cnt_q[0] ? b_q[31:16] : b_q[15:0]};
    end
  end

  // Tag at stage L lines up with the cell result for the pair it describes
  assign cap_vld  = tag_vld_q[L];
  assign cap_idx  = tag_idx_q[L];
  assign cap_last = cap_vld && (cap_idx == last_idx);

  always_comb begin
    term = {32'h0, M_mul_cell_result};
    case (cap_idx)
      2'd0:    term = {32'h0, M_mul_cell_result};
      2'd3:    term = {M_mul_cell_result, 32'h0};
      default: term = {16'h0, M_mul_cell_result, 16'h0};
    endcase
    acc_d = acc_q + term;
    case (op_q)
      2'b00:   final_d = M_mul_cell_result;
      2'b01:   final_d = acc_d[63:32];
      2'b10:   final_d = acc_d[63:32] - (a_q[31] ? b_q : 32'h0);
      default: final_d = acc_d[63:32] - (a_q[31] ? b_q : 32'h0) - (b_q[31] ? a_q : 32'h0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      acc_q       <= 64'h0;
      issue_cnt_q <= 2'd0;
      tag_vld_q   <= '0;
      for (int i = 0; i <= L; i++) tag_idx_q[i] <= 2'd0;
      M_mul_src1  <= '0;
      M_mul_src2  <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
    end else begin
      tag_vld_q    <= {tag_vld_q[L-1:0], 1'b0};
      tag_idx_q[0] <= issue_cnt_q;
      for (int i = 1; i <= L; i++) tag_idx_q[i] <= tag_idx_q[i-1];
      M_mul_src1 <= '0;
      M_mul_src2 <= '0;
      if (flush) begin
        state_q     <= IDLE;
        rsp_valid   <= 1'b0;
        tag_vld_q   <= '0;
        issue_cnt_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              op_q        <= req_op;
              a_q         <= req_src1;
              b_q         <= req_src2;
              acc_q       <= 64'h0;
              issue_cnt_q <= 2'd0;
              state_q     <= ISSUE;
            end
          end
          ISSUE: begin
            M_mul_src1   <= pair_a_d;
            M_mul_src2   <= pair_b_d;
            tag_vld_q[0] <= 1'b1;
            if (issue_cnt_q == last_idx) begin
              issue_cnt_q <= 2'd0;
              state_q     <= WAIT;
            end else begin
              issue_cnt_q <= issue_cnt_q + 2'd1;
            end
          end
          DONE: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: ;
        endcase
        // The last capture can only arrive after issuing finished, so it never races ISSUE
        if (cap_vld) begin
          acc_q <= acc_d;
          if (cap_last) begin
            rsp_data  <= final_d;
            rsp_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_cpu_mul_seq.sv
// tb/tb_nios_cpu_mul_seq.sv - scoreboard bench for the multiply sequencer with a behavioural cell model
module tb_nios_cpu_mul_seq;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = 32'h0;
  logic [31:0] req_src2 = 32'h0;
  logic [31:0] M_mul_src1, M_mul_src2, M_mul_cell_result;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_ready = 1'b1;

  nios_cpu_mul_seq #(.MUL_CELL_LATENCY(L), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .M_mul_src1(M_mul_src1), .M_mul_src2(M_mul_src2),
    .M_mul_cell_result(M_mul_cell_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Registered multiplier cell, L cycles from operands to low-word product
  logic [31:0] cell_pipe [L];
  always @(posedge clk) begin
    cell_pipe[0] <= M_mul_src1 * M_mul_src2;
    for (int i = 1; i < L; i++) cell_pipe[i] <= cell_pipe[i-1];
  end
  assign M_mul_cell_result = cell_pipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int acc; int lat; } rsp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; int due; } pair_t;
  rsp_t  rq[$];
  pair_t pq[$];

  int n_cmp = 0;
  int n_fail = 0;
  logic rand_bp = 1'b0;
  logic prev_valid = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_data = 32'h0;
  int last_hs_edge = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-precision signed/unsigned product, pick the requested word
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, p;
    sa = (op[1] && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    sb = (op == 2'b11 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int acc_edge);
    bit got = 0;
    rsp_t r;
    pair_t p;
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    acc_edge = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (req_ready && !flush && !reset) begin
        got = 1;
        acc_edge = cyc + 1;
        r.data = ref_mul(op, a, b);
        r.acc  = acc_edge;
        r.lat  = ((op == 2'b00) ? 1 : 4) + L + 1;
        rq.push_back(r);
        if (op == 2'b00) begin
          p.a = a; p.b = b; p.due = acc_edge + 1;
          pq.push_back(p);
        end else begin
          for (int j = 0; j < 4; j++) begin
            p.a = {16'h0, (j >= 2) ? a[31:16] : a[15:0]};
            p.b = {16'h0, (j % 2 == 1) ? b[31:16] : b[15:0]};
            p.due = acc_edge + 1 + j;
            pq.push_back(p);
          end
        end
      end
    end
    if (!got) chk("accept timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_src1 = $urandom; req_src2 = $urandom;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 300 && rq.size() != 0; k++) @(posedge clk);
    #1;
    if (rq.size() != 0) chk("drain timeout", rq.size(), 32'h0);
  endtask

  // Monitor: operand pairs, response latency/data, hold behaviour and busy req_ready
  always @(negedge clk) begin
    if (!reset) begin
      if (pq.size() != 0 && pq[0].due == cyc) begin
        chk("cell src1", M_mul_src1, pq[0].a);
        chk("cell src2", M_mul_src2, pq[0].b);
        void'(pq.pop_front());
      end else if (M_mul_src1 != 0 || M_mul_src2 != 0) begin
        chk("idle cell src1", M_mul_src1, 32'h0);
        chk("idle cell src2", M_mul_src2, 32'h0);
      end
      if (rq.size() != 0 && cyc >= rq[0].acc) chk("req_ready busy", req_ready, 32'h0);
      if (rsp_valid && !prev_valid) begin
        if (rq.size() == 0) chk("unexpected rsp_valid", 32'h1, 32'h0);
        else chk("rsp latency", cyc - rq[0].acc, rq[0].lat);
      end
      if (rsp_valid && prev_valid && !prev_hs) chk("rsp_data hold", rsp_data, prev_data);
      if (rsp_valid && rsp_ready) begin
        last_hs_edge = cyc + 1;
        if (rq.size() != 0) begin
          chk("rsp_data", rsp_data, rq[0].data);
          void'(rq.pop_front());
        end
      end
      prev_valid = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_data  = rsp_data;
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, hs;
    logic [1:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", req_ready, 32'h0);
    chk("reset rsp_valid", rsp_valid, 32'h0);
    chk("reset rsp_data", rsp_data, 32'h0);
    chk("reset src1", M_mul_src1, 32'h0);
    chk("reset src2", M_mul_src2, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("req_ready after reset", req_ready, 32'h1);
    @(posedge clk); #1;

    issue(2'b00, 32'h0001_2345, 32'h0000_0010, acc); drain();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc); drain();
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, acc); drain();
    issue(2'b11, 32'h8000_0000, 32'h8000_0000, acc); drain();
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc); drain();
    issue(2'b10, 32'h0000_0003, 32'h8000_0000, acc); drain();

    rsp_ready = 1'b0;
    issue(2'b00, 32'd7, 32'd6, acc);
    for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    hs = cyc + 1;
    issue(2'b00, 32'd9, 32'd11, acc);
    chk("back-to-back accept edge", acc, hs + 1);
    chk("handshake edge", last_hs_edge, hs);
    drain();

    issue(2'b11, 32'h1234_5678, 32'h8765_4321, acc);
    @(posedge clk); @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    rq.delete(); pq.delete();
    @(negedge clk);
    chk("req_ready after flush", req_ready, 32'h1);
    chk("rsp_valid after flush", rsp_valid, 32'h0);
    repeat (8) @(posedge clk); #1;
    issue(2'b00, 32'd3, 32'd5, acc); drain();

    issue(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, acc);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rq.delete(); pq.delete();
    prev_valid = 1'b0; prev_hs = 1'b0;
    @(negedge clk);
    chk("reset-abort src1", M_mul_src1, 32'h0);
    chk("reset-abort src2", M_mul_src2, 32'h0);
    chk("reset-abort rsp_valid", rsp_valid, 32'h0);
    chk("reset-abort rsp_data", rsp_data, 32'h0);
    chk("reset-abort req_ready", req_ready, 32'h1);
    repeat (6) @(posedge clk); #1;

    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin a = 32'h8000_0000; b = $urandom; end
        1:       begin a = $urandom; b = 32'hFFFF_FFFF; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      issue(op, a, b, acc);
      drain();
    end
    rand_bp = 1'b0;
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
